// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and default bus widths
package cpu_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_REDIR = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/ins_fetch_if.sv
// rtl/ins_fetch_if.sv - program-memory, decoder and redirect signals of the fetch stage
interface ins_fetch_if #(
  parameter int ADDR_W = cpu_pkg::DEF_ADDR_W,
  parameter int DATA_W = cpu_pkg::DEF_DATA_W
);
  logic [ADDR_W-1:0] addr_bus;
  logic              read_en;
  logic [DATA_W-1:0] data_bus;
  logic [DATA_W-1:0] ins_byte;
  logic [ADDR_W-1:0] ins_pc;
  logic              ins_valid;
  logic              ins_ready;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;

  modport master (
    output addr_bus, read_en, ins_byte, ins_pc, ins_valid,
    input  data_bus, ins_ready, jump_en, jump_addr
  );

  modport slave (
    input  addr_bus, read_en, ins_byte, ins_pc, ins_valid,
    output data_bus, ins_ready, jump_en, jump_addr
  );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch buffer of {byte, pc} entries; flush beats push and pop
module fetch_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // When full, push and pop share the slot being vacated by the head.
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/ins_fetch.sv
// rtl/ins_fetch.sv - instruction fetch stage: fetch PC, memory read strobe, prefetch buffer
module ins_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 4
) (
  input logic        clk,
  input logic        reset,
  ins_fetch_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = DATA_W + ADDR_W;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic              pop;
  logic              read_en;

  assign pop     = bus.ins_valid && bus.ins_ready;
  assign read_en = (state_q == S_RUN) && !bus.jump_en && (count != FULL || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.jump_en) begin
      state_d = S_REDIR;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN:   state_d = S_RUN;
        S_REDIR: state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           fetch_pc <= '0;
    else if (bus.jump_en) fetch_pc <= bus.jump_addr;
    else if (read_en)     fetch_pc <= fetch_pc + 1'b1;
  end

  // A redirect flushes the buffer, which also discards any pop that cycle.
  fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (read_en),
    .pop   (pop),
    .flush (bus.jump_en),
    .din   ({bus.data_bus, fetch_pc}),
    .head  (head),
    .count (count)
  );

  assign bus.addr_bus  = fetch_pc;
  assign bus.read_en   = read_en;
  assign bus.ins_valid = (count != '0);
  assign bus.ins_byte  = head[EW-1 -: DATA_W];
  assign bus.ins_pc    = head[ADDR_W-1:0];
endmodule

// File: doc/ins_fetch.md
# ins_fetch

Instruction fetch stage of the CPU. Owns the fetch program counter, drives the program-memory bus (`addr_bus`, `read_en`, sampled `data_bus`), and buffers fetched opcode/operand bytes in a small prefetch FIFO. It presents the bytes to the decoder through a valid/ready handshake. A jump/branch redirect from the execute stage flushes the buffer and restarts fetching at the new address.

## Interface
- `ADDR_W`, 8: program address width.
- `DATA_W`, 8: instruction byte width.
- `DEPTH`, 4: prefetch FIFO entries; must be a power of two and at least 2.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_bus`  in  DATA_W  program memory read data; valid during any cycle with `read_en`=1.
- `addr_bus`  out  ADDR_W  fetch address; equals the fetch PC.
- `read_en`  out  1  memory read strobe; one byte per cycle.
- `ins_byte`  out  DATA_W  FIFO head byte.
- `ins_pc`  out  ADDR_W  address the head byte was fetched from.
- `ins_valid`  out  1  head entry present.
- `ins_ready`  in  1  decoder consumes head this cycle.
- `jump_en`  in  1  redirect request, single-cycle.
- `jump_addr`  in  ADDR_W  redirect target.

## Operation
- FSM states: S_IDLE, S_RUN, S_REDIR.
  - S_IDLE is entered on reset and goes to S_RUN on the next edge.
  - S_RUN goes to S_REDIR on `jump_en`.
  - S_REDIR goes to S_RUN on the next edge, unless `jump_en` is asserted again, in which case it reloads and stays in S_REDIR.
- Pop: `ins_valid && ins_ready` removes the head at the edge.
- `read_en` is combinational: `state==S_RUN && !jump_en && (count<DEPTH || pop)`. A full FIFO with a simultaneous pop still fetches.
- Fetch: at an edge with `read_en`=1, the entry {`data_bus`, fetch_pc} is pushed. fetch_pc increments modulo 2^ADDR_W, so 0xFF wraps to 0x00.
- `addr_bus` = fetch_pc at all times, including when `read_en`=0.
- Push and pop in the same cycle leave count unchanged.
- There is no bypass: a fetched byte becomes visible only after the edge that writes it.
- Jump has priority over fetch and pop. At an edge with `jump_en`=1:
  - count clears to 0;
  - fetch_pc loads `jump_addr`;
  - state goes to S_REDIR;
  - any pop that cycle is ignored.
- `ins_valid` is combinational from the stored state in the same cycle as `jump_en`; the head is still shown but is discarded.
- `ins_valid` = (count != 0). `ins_byte`/`ins_pc` are don't-care when `ins_valid`=0.
- When `ins_valid`=0, `ins_ready` is ignored.

## Timing
- Reset values:
  - `read_en`=0, `ins_valid`=0, `addr_bus`=0;
  - `ins_byte`=0 and `ins_pc`=0 (storage cleared);
  - state=S_IDLE, count=0.
- Reset mid-operation discards all buffered bytes immediately (asynchronous).
- Startup: edge E0 after reset deassertion moves S_IDLE to S_RUN. `read_en`=1 in the cycle after E0, with `addr_bus`=0. `ins_valid`=1 after edge E1.
- Steady state with `ins_ready` held at 1: one byte per cycle, no bubbles.
- Redirect: `jump_en` sampled at edge J.
  - `read_en`=0 in the cycle before J and in the S_REDIR cycle after J.
  - `read_en`=1 with `addr_bus`=`jump_addr` after edge J+1.
  - The first target byte is valid after edge J+2.
- Decoder stall (`ins_ready`=0): the FIFO fills to DEPTH, then `read_en`=0 and `addr_bus` holds.

## Structure
- Package `cpu_pkg`:
  - `fetch_state_t` enum {S_IDLE, S_RUN, S_REDIR};
  - default `ADDR_W`/`DATA_W` constants, shared with the decoder and the bus model.
- Sub-module `fetch_fifo` (DEPTH×(DATA_W+ADDR_W)):
  - inputs: push, pop, flush;
  - outputs: count, head;
  - pointers wrap modulo DEPTH;
  - flush has priority over push and pop.
- `ins_fetch` contains the FSM, fetch_pc and the `read_en` logic.

## Test plan
- Reset then free run: memory returns byte = addr+0x10, `ins_ready`=1. Required: `addr_bus` is 0, 1, 2… each cycle; `ins_byte` is 0x10, 0x11… in order with matching `ins_pc`; `ins_valid` stays high from E1 on.
- Stall: `ins_ready`=0 for 10 cycles from startup. Required: exactly 4 reads (addr 0–3); `read_en`=0 afterwards; `addr_bus`=4 held. Release: bytes 0x10–0x13 are delivered, then fetching resumes at 4 with no loss.
- Full plus pop: with count=4, pulse `ins_ready` for 1 cycle. Required: `read_en`=1 that cycle and count stays at 4.
- Jump: `jump_en` with `jump_addr`=0x40 while 3 bytes are buffered. Required: count=0; one bubble cycle; next read at 0x40; next valid byte 0x50 with `ins_pc`=0x40. Back-to-back jumps to 0x40 then 0x80 must fetch 0x80 first.
- Wrap: `jump_addr`=0xFE, free run. Required: addresses 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-run: assert `reset` low with 2 bytes buffered. Required: `ins_valid` and `read_en` drop immediately; restart from addr 0.
